fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 20 ++
 rtl/fetch_unit.sv | 54 +++++
 tb/tb_fetch_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-to-decode and instruction-memory signals of the fetch unit
interface fetch_unit_if;
  logic        stall;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic [7:0]  im_addr;
  logic [12:0] im_data;
  logic [12:0] instr;
  logic        instr_valid;
  logic [7:0]  instr_pc;
  logic        halted;
  modport master (
    input  stall, jump_en, jump_addr, im_data,
    output im_addr, instr, instr_valid, instr_pc, halted
  );
  modport slave (
    output stall, jump_en, jump_addr, im_data,
    input  im_addr, instr, instr_valid, instr_pc, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-stage instruction fetch with stall, redirect and end-of-program halt
module fetch_unit #(
  parameter int LAST_ADDR = 24
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  typedef enum logic {FETCH, HALT} state_e;
  localparam logic [7:0] LAST = 8'(LAST_ADDR);
  state_e      state_q;
  logic [7:0]  pc_q;
  logic [12:0] ir_q;
  logic [7:0]  ir_pc_q;
  logic        valid_q;
  logic        halt_q;
  assign bus.im_addr     = pc_q;
  assign bus.instr       = ir_q;
  assign bus.instr_pc    = ir_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      ir_pc_q <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else if (state_q == FETCH) begin
      if (bus.jump_en) begin
        pc_q    <= bus.jump_addr;
        valid_q <= 1'b0;
        if (bus.jump_addr > LAST) begin
          state_q <= HALT;
          halt_q  <= 1'b1;
        end
      end else if (!bus.stall) begin
        ir_q    <= bus.im_data;
        ir_pc_q <= pc_q;
        valid_q <= 1'b1;
        // PC parks on the last address instead of incrementing, so it never wraps
        if (pc_q == LAST) begin
          state_q <= HALT;
          halt_q  <= 1'b1;
        end else begin
          pc_q <= pc_q + 8'd1;
        end
      end
    end else begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch sequencing, stall, redirect, halt and reset
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  fetch_unit_if bus ();
  fetch_unit #(.LAST_ADDR(24)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  function automatic logic [12:0] mem_f(input logic [7:0] a);
    return {a[4:0], a} ^ 13'h0a5a;
  endfunction
  assign bus.im_data = mem_f(bus.im_addr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.stall = 1'b1;
    bus.jump_en = 1'b1;
    bus.jump_addr = 8'h40;
    step();
    step();
    chk("rst_instr", 32'(bus.instr), 0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_pc", 32'(bus.instr_pc), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.jump_en = 1'b0;
    chk("rst_im_addr", 32'(bus.im_addr), 0);
  endtask
  task automatic free_run();
    for (int a = 0; a <= 24; a++) begin
      step();
      chk("run_valid", 32'(bus.instr_valid), 1);
      chk("run_pc", 32'(bus.instr_pc), 32'(a));
      chk("run_instr", 32'(bus.instr), 32'(mem_f(8'(a))));
      chk("run_halted", 32'(bus.halted), (a == 24) ? 1 : 0);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk("end_valid", 32'(bus.instr_valid), 0);
      chk("end_halted", 32'(bus.halted), 1);
      chk("end_im_addr", 32'(bus.im_addr), 24);
      chk("end_pc", 32'(bus.instr_pc), 24);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.jump_en = 1'b0;
    bus.jump_addr = '0;
    do_reset();
    free_run();
    do_reset();
    for (int a = 0; a <= 5; a++) begin
      step();
      chk("pre_pc", 32'(bus.instr_pc), 32'(a));
    end
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", 32'(bus.instr_pc), 5);
      chk("stall_im_addr", 32'(bus.im_addr), 6);
      chk("stall_valid", 32'(bus.instr_valid), 1);
    end
    bus.stall = 1'b0;
    step();
    chk("unstall_pc", 32'(bus.instr_pc), 6);
    step();
    chk("pre_jump_pc", 32'(bus.instr_pc), 7);
    bus.jump_en = 1'b1;
    bus.jump_addr = 8'h10;
    step();
    bus.jump_en = 1'b0;
    chk("jump_valid", 32'(bus.instr_valid), 0);
    chk("jump_pc_hold", 32'(bus.instr_pc), 7);
    chk("jump_im_addr", 32'(bus.im_addr), 8'h10);
    step();
    chk("jump_tgt_pc", 32'(bus.instr_pc), 8'h10);
    chk("jump_tgt_instr", 32'(bus.instr), 32'(mem_f(8'h10)));
    chk("jump_tgt_valid", 32'(bus.instr_valid), 1);
    bus.stall = 1'b1;
    bus.jump_en = 1'b1;
    bus.jump_addr = 8'h03;
    step();
    bus.stall = 1'b0;
    bus.jump_en = 1'b0;
    chk("prio_valid", 32'(bus.instr_valid), 0);
    chk("prio_im_addr", 32'(bus.im_addr), 3);
    step();
    chk("prio_pc", 32'(bus.instr_pc), 3);
    chk("prio_instr", 32'(bus.instr), 32'(mem_f(8'h03)));
    bus.jump_en = 1'b1;
    bus.jump_addr = 8'h30;
    step();
    bus.jump_en = 1'b0;
    chk("oob_valid", 32'(bus.instr_valid), 0);
    chk("oob_halted", 32'(bus.halted), 1);
    chk("oob_im_addr", 32'(bus.im_addr), 8'h30);
    step();
    bus.jump_en = 1'b1;
    bus.jump_addr = 8'h05;
    bus.stall = 1'b1;
    step();
    step();
    bus.jump_en = 1'b0;
    bus.stall = 1'b0;
    chk("hold_im_addr", 32'(bus.im_addr), 8'h30);
    chk("hold_pc", 32'(bus.instr_pc), 3);
    chk("hold_instr", 32'(bus.instr), 32'(mem_f(8'h03)));
    chk("hold_valid", 32'(bus.instr_valid), 0);
    chk("hold_halted", 32'(bus.halted), 1);
    do_reset();
    free_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
